approx_csr_bank: RTL
====================

# approx_csr_bank

Parametrised control/status register bank for the phoeniX core, successor to the fixed three-register approximation CSR file. It holds `NUM_UNITS` approximation-control CSRs at consecutive indices starting at `BASE_INDEX`, supports RISC-V write/set/clear semantics, and exports every control word to the execution units. It also maintains read-only 64-bit `cycle` and `instret` counters and flags illegal accesses. The block sits beside the register file and is accessed from the execute stage.

## Interface
- `NUM_UNITS`, default 3, number of approximation CSRs, legal range 1..16.
- `BASE_INDEX`, default 12'h800, CSR index of unit 0; unit k sits at `BASE_INDEX + k`.
- `COUNTERS_EN`, default 1, 1 = implement cycle/instret counters; 0 = counter indices are unmapped.

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `read_enable_csr`  in  1  read access this cycle.
- `write_enable_csr`  in  1  write access this cycle.
- `csr_op`  in  2  01 = write, 10 = set bits, 11 = clear bits, 00 = no state change.
- `csr_read_index`  in  12  index for the read port.
- `csr_write_index`  in  12  index for the write port.
- `csr_write_data`  in  32  write data or set/clear mask.
- `instret_inc`  in  1  one instruction retired this cycle.
- `csr_read_data`  out  32  read result, combinational.
- `csr_illegal`  out  1  combinational; the current access targets an unmapped index, or writes a read-only index.
- `approx_ctrl`  out  32*NUM_UNITS  registered control words; unit k in bits [32k+31:32k].

## Operation
- Decoded map: `BASE_INDEX`..`BASE_INDEX+NUM_UNITS-1` read/write. With `COUNTERS_EN`=1, the following are read-only: 12'hC00 `cycle`[31:0], 12'hC80 `cycle`[63:32], 12'hC02 `instret`[31:0], 12'hC82 `instret`[63:32]. All other indices are unmapped.
- Read: if `read_enable_csr` and the index is mapped, `csr_read_data` = current register value. In every other case, including read disabled, `csr_read_data` = 0. The output never floats.
- Write, effective only when `write_enable_csr` is high, the index is mapped read/write, and `csr_op`≠00:
  - op 01: reg ← data.
  - op 10: reg ← reg | data.
  - op 11: reg ← reg & ~data.
- A write to an unmapped or read-only index leaves all state unchanged and asserts `csr_illegal` that cycle.
- `csr_illegal` = (read_enable & read index unmapped) | (write_enable & op≠00 & write index unmapped or read-only).
- `cycle` increments by 1 every cycle that `reset` is low. `instret` increments by 1 on each edge where `instret_inc` is high and `reset` is low. Both wrap from 2^64−1 to 0. A carry from [31:0] into [63:32] takes effect in the same edge.
- `approx_ctrl` is the registered CSR contents driven directly, with no extra pipeline stage.

## Timing
- Reset: on a rising edge with `reset` high, all CSRs, `cycle` and `instret` become 0. `reset` wins over a simultaneous write and over counter increments. Consequently `approx_ctrl` = 0 and a read of any mapped index returns 0 in the cycle after reset.
- Write latency: 1 edge. The new value is visible on `approx_ctrl` and via reads in the cycle after the write edge.
- Same-cycle read and write of the same index: the read returns the old value (no forwarding).
- Read latency: 0 cycles (combinational from index and state).
- Reading `cycle` low in cycle n returns the count of non-reset edges before cycle n. High and low halves are read in separate accesses; software handles tearing.
- Reset asserted mid-sequence: the state in progress is discarded, and counting restarts from 0 on the first edge with `reset` low.

## Test plan
- Reset: hold `reset` 2 cycles after random writes. Then: `approx_ctrl` = 0, reads of 0x800/0x801/0x802 return 0, and reading 0xC00 in the first cycle after reset returns 0.
- Write/set/clear on 0x801: write 0x0000_00F0, then set 0x0000_000F, then clear 0x0000_0030. Reads return 0xF0, then 0xFF, then 0xCF, and `approx_ctrl`[63:32] tracks each value one cycle after its write.
- Illegal access: write 0x1234 to 0xC00, and separately to 0x803 with `NUM_UNITS`=3. `csr_illegal`=1 in both cycles, no state changes, and the read of 0x7FF returns 0 with `csr_illegal`=1.
- Counter wrap: force `cycle` = 0x0000_0000_FFFF_FFFF and run 1 cycle. Reading 0xC80 returns 1 and 0xC00 returns 0. Pulse `instret_inc` 5 times in 10 cycles; reading 0xC02 returns 5.
- Simultaneous events: in the same cycle, write 0xAA to 0x800 and read 0x800 with prior value 0x11. The read returns 0x11 and the next cycle returns 0xAA. In a second case, write 0x55 with `reset` high: the value afterwards is 0.
- Parametrisation: build with `NUM_UNITS`=8 and `BASE_INDEX`=12'h7C0. Write k+1 to 0x7C0+k for k = 0..7, then check each `approx_ctrl` slice equals k+1. Build with `COUNTERS_EN`=0: a read of 0xC00 asserts `csr_illegal`.

Source files
------------

// File: rtl/approx_csr_bank.sv
// rtl/approx_csr_bank.sv - parametrised approximation-control CSR bank with cycle/instret counters
module approx_csr_bank #(
    parameter int          NUM_UNITS   = 3,
    parameter logic [11:0] BASE_INDEX  = 12'h800,
    parameter bit          COUNTERS_EN = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      read_enable_csr,
    input  logic                      write_enable_csr,
    input  logic [1:0]                csr_op,
    input  logic [11:0]               csr_read_index,
    input  logic [11:0]               csr_write_index,
    input  logic [31:0]               csr_write_data,
    input  logic                      instret_inc,
    output logic [31:0]               csr_read_data,
    output logic                      csr_illegal,
    output logic [32*NUM_UNITS-1:0]   approx_ctrl
);

    localparam logic [11:0] IDX_CYCLE    = 12'hC00;
    localparam logic [11:0] IDX_CYCLEH   = 12'hC80;
    localparam logic [11:0] IDX_INSTRET  = 12'hC02;
    localparam logic [11:0] IDX_INSTRETH = 12'hC82;

    logic [31:0]          ctrl_q [NUM_UNITS];
    logic [63:0]          cycle_q;
    logic [63:0]          instret_q;
    logic [NUM_UNITS-1:0] wr_sel;
    logic                 wr_active;
    logic                 rd_hit;
    logic [31:0]          rd_data;

    function automatic logic [31:0] apply_op(input logic [1:0] op,
                                             input logic [31:0] cur,
                                             input logic [31:0] data);
        case (op)
            2'b01:   apply_op = data;
            2'b10:   apply_op = cur | data;
            2'b11:   apply_op = cur & ~data;
            default: apply_op = cur;
        endcase
    endfunction

    always_comb begin
        rd_hit  = 1'b0;
        rd_data = 32'h0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (csr_read_index == BASE_INDEX + 12'(k)) begin
                rd_hit  = 1'b1;
                rd_data = ctrl_q[k];
            end
        end
        if (COUNTERS_EN) begin
            case (csr_read_index)
                IDX_CYCLE:    begin rd_hit = 1'b1; rd_data = cycle_q[31:0];    end
                IDX_CYCLEH:   begin rd_hit = 1'b1; rd_data = cycle_q[63:32];   end
                IDX_INSTRET:  begin rd_hit = 1'b1; rd_data = instret_q[31:0];  end
                IDX_INSTRETH: begin rd_hit = 1'b1; rd_data = instret_q[63:32]; end
                default: ;
            endcase
        end
    end

    // Counter indices are never writable, so only the approximation CSRs count as a legal write target.
    always_comb begin
        wr_sel = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            wr_sel[k] = (csr_write_index == BASE_INDEX + 12'(k));
        end
    end

    assign wr_active     = write_enable_csr && (csr_op != 2'b00);
    assign csr_illegal   = (read_enable_csr && !rd_hit) || (wr_active && (wr_sel == '0));
    assign csr_read_data = read_enable_csr ? rd_data : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= 64'h0;
            instret_q <= 64'h0;
            for (int k = 0; k < NUM_UNITS; k++) begin
                ctrl_q[k] <= 32'h0;
            end
        end else begin
            cycle_q <= cycle_q + 64'd1;
            if (instret_inc) begin
                instret_q <= instret_q + 64'd1;
            end
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (wr_active && wr_sel[k]) begin
                    ctrl_q[k] <= apply_op(csr_op, ctrl_q[k], csr_write_data);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_out
        assign approx_ctrl[32*g +: 32] = ctrl_q[g];
    end

endmodule
